// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared MODE encodings, cell select codes and counter width helper
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    // Per-cell next-state source; decoded once in the top and shared by all cells.
    typedef enum logic [2:0] {
        CSEL_HOLD = 3'd0,
        CSEL_LOAD = 3'd1,
        CSEL_LO   = 3'd2,   // take the lower neighbour (left shift / rotate)
        CSEL_HI   = 3'd3,   // take the upper neighbour (right shift / rotate)
        CSEL_ZERO = 3'd4
    } csel_e;

    // CNT must hold values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shreg_cell.sv
// rtl/shreg_cell.sv - one storage bit of the universal shift register
//   ck  : clock, active edge chosen by CK_NEG
//   rn  : asynchronous active-low reset, loads RST_BIT
//   sel : next-state source
//   d   : parallel load bit
//   lo  : bit from the lower neighbour (or SIL / rotate feedback at bit 0)
//   hi  : bit from the upper neighbour (or SIR / rotate feedback at the MSB)
//   q   : stored bit
module shreg_cell
    import shreg_pkg::*;
#(
    parameter bit CK_NEG  = 1'b1,
    parameter bit RST_BIT = 1'b0
) (
    input  logic  ck,
    input  logic  rn,
    input  csel_e sel,
    input  logic  d,
    input  logic  lo,
    input  logic  hi,
    output logic  q
);

    logic nxt;
    logic ck_act;

    // Inverting the clock lets one posedge flop serve both edge polarities.
    assign ck_act = ck ^ CK_NEG;

    always_comb begin
        nxt = q;
        case (sel)
            CSEL_HOLD: nxt = q;
            CSEL_LOAD: nxt = d;
            CSEL_LO:   nxt = lo;
            CSEL_HI:   nxt = hi;
            CSEL_ZERO: nxt = 1'b0;
            default:   nxt = q;
        endcase
    end

    always_ff @(posedge ck_act or negedge rn) begin
        if (!rn) begin
            q <= RST_BIT;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/shreg_univ.sv
// rtl/shreg_univ.sv - universal shift register with shift counter and DONE flag
//   CK    : clock, falling edge active when CK_NEG=1, rising when 0
//   RN    : asynchronous active-low reset (Q=RESET_VAL, CNT=0, DONE=0)
//   MODE  : HOLD/LOAD/SHL/SHR/ROL/ROR/CLR, 111 acts as HOLD
//   EN    : operation enable, 0 forces hold
//   D     : parallel load data
//   SIL   : serial input at bit 0 on SHL
//   SIR   : serial input at the MSB on SHR
//   Q     : register contents
//   SOL   : Q MSB
//   SOR   : Q LSB
//   CNT   : shifts since last load/clear, saturating at WIDTH
//   DONE  : CNT == WIDTH
module shreg_univ
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               CK_NEG    = 1'b1,
    localparam int              CW        = cnt_width(WIDTH)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [2:0]       MODE,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR,
    output logic [CW-1:0]    CNT,
    output logic             DONE
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    csel_e            sel;
    logic             is_shift;
    logic             lo_edge;
    logic             hi_edge;
    logic [WIDTH-1:0] lo_vec;
    logic [WIDTH-1:0] hi_vec;
    logic             ck_act;

    assign ck_act = CK ^ CK_NEG;

    always_comb begin
        sel      = CSEL_HOLD;
        is_shift = 1'b0;
        if (EN) begin
            case (MODE)
                MODE_LOAD: sel = CSEL_LOAD;
                MODE_SHL,
                MODE_ROL: begin
                    sel      = CSEL_LO;
                    is_shift = 1'b1;
                end
                MODE_SHR,
                MODE_ROR: begin
                    sel      = CSEL_HI;
                    is_shift = 1'b1;
                end
                MODE_CLR:  sel = CSEL_ZERO;
                default:   sel = CSEL_HOLD;
            endcase
        end
    end

    // Only the end bits differ between shift and rotate: they take the
    // serial input or the bit wrapping round from the opposite end.
    assign lo_edge = (MODE == MODE_ROL) ? Q[WIDTH-1] : SIL;
    assign hi_edge = (MODE == MODE_ROR) ? Q[0]       : SIR;
    assign lo_vec  = {Q[WIDTH-2:0], lo_edge};
    assign hi_vec  = {hi_edge, Q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        shreg_cell #(
            .CK_NEG  (CK_NEG),
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .ck  (CK),
            .rn  (RN),
            .sel (sel),
            .d   (D[i]),
            .lo  (lo_vec[i]),
            .hi  (hi_vec[i]),
            .q   (Q[i])
        );
    end

    assign SOL = Q[WIDTH-1];
    assign SOR = Q[0];

    // DONE is set on the same edge that takes CNT to WIDTH; once saturated
    // both stay put while data keeps moving.
    always_ff @(posedge ck_act or negedge RN) begin
        if (!RN) begin
            CNT  <= '0;
            DONE <= 1'b0;
        end else if (sel == CSEL_LOAD || sel == CSEL_ZERO) begin
            CNT  <= '0;
            DONE <= 1'b0;
        end else if (is_shift && CNT != CNT_MAX) begin
            CNT  <= CNT + 1'b1;
            DONE <= (CNT == CNT_MAX - 1'b1);
        end
    end

endmodule
